divide_32: RTL and testbench

Iterative restoring divider for the 32-bit RISC datapath. It complements the combinational multiply unit by providing the inverse operation, quotient and remainder, for the DIV/DIVU/REM/REMU function selects. It takes operands through a start/done handshake and runs one quotient bit per clock. The ALU stalls on `busy` and captures results on `done`.

---
 rtl/divide_32_pkg.sv | 28 ++
 rtl/divide_32_step.sv | 31 +++
 rtl/divide_32.sv | 147 ++++++++++++++
 tb/tb_divide_32.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/divide_32_pkg.sv
// rtl/divide_32_pkg.sv - shared divider types, constants and ALU function selects
//
// Purpose : common definitions for the iterative divider and the ALU decode.
// Contents: div_state_t FSM encoding, DIV_WIDTH / DIV_LATENCY, the
//           DIV/DIVU/REM/REMU function-select codes and a decode helper.
package divide_32_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Function-select codes as carried in the instruction funct3 field.
  localparam logic [2:0] FSEL_DIV  = 3'b100;
  localparam logic [2:0] FSEL_DIVU = 3'b101;
  localparam logic [2:0] FSEL_REM  = 3'b110;
  localparam logic [2:0] FSEL_REMU = 3'b111;

  // Signed operations are the even encodings (DIV, REM).
  function automatic logic div_is_signed(input logic [2:0] fsel);
    return (fsel == FSEL_DIV) || (fsel == FSEL_REM);
  endfunction

endpackage

// File: rtl/divide_32_step.sv
// rtl/divide_32_step.sv - one restoring-division iteration on {rem, quo}
//
// Purpose : combinational shift / trial-subtract / select for one quotient bit.
// Ports   : i_rem, i_quo  - current partial remainder and quotient register
//           i_divisor     - divisor magnitude
//           o_rem, o_quo  - register contents after this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // Shifted remainder needs WIDTH+1 bits: 2*rem+1 can exceed WIDTH bits.
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_trial;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});
  // When the divisor fits the difference is below the divisor, so the
  // modulo-2^WIDTH subtract is exact.
  assign w_trial = w_shift[WIDTH-1:0] - i_divisor;

  assign o_rem = w_fits ? w_trial : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/divide_32.sv
// rtl/divide_32.sv - iterative signed/unsigned restoring divider, one bit per clock
//
// Purpose : quotient and remainder for DIV/DIVU/REM/REMU with start/done handshake.
// Ports   : clk, rst_n            - clock, async active-low reset
//           i_start, i_signed_op  - request (sampled in IDLE), signed select
//           i_dividend, i_divisor - operands, sampled with i_start
//           o_quotient, o_remainder, o_div_by_zero - results, held until next finish
//           o_busy                - high from the cycle after accept until done
//           o_done                - single-cycle pulse, results valid
module divide_32
  import divide_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_next_state;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_zero;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Operand magnitudes; the most negative value maps to itself, which is
  // the correct unsigned magnitude 2^(WIDTH-1).
  assign w_dvd_neg = i_signed_op & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_signed_op & i_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_dvsr),
    .o_rem    (w_rem_nxt),
    .o_quo    (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = CALC;
      CALC:    if (r_cnt == '0) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvsr  <= w_dvs_mag;
            r_cnt   <= CNT_INIT;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            r_zero  <= (i_divisor == '0);
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        FINISH: begin
          // A zero divisor leaves |dividend| in rem, so the normal sign
          // correction already restores the original dividend; only the
          // quotient needs forcing to all ones.
          if (r_zero) begin
            r_quotient <= '1;
          end else begin
            r_quotient <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
          end
          r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
          r_dbz       <= r_zero;
          r_done      <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divide_32.sv
// tb/tb_divide_32.sv - randomized self-checking bench for divide_32
module tb_divide_32;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_signed_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;

  int n_tests;
  int n_fail;

  divide_32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_signed_op  (i_signed_op),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_div_by_zero(o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: language-level division semantics plus the documented
  // divide-by-zero and signed-overflow results.
  function automatic void ref_div(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    z = (b == 32'd0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sop) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  task automatic issue(input logic sop, input logic [31:0] a, input logic [31:0] b);
    i_start     = 1'b1;
    i_signed_op = sop;
    i_dividend  = a;
    i_divisor   = b;
  endtask

  // Called on the negedge where start was raised; returns on the done negedge
  // (or one cycle later when the single-pulse check runs).
  task automatic wait_check(input string nm, input logic sop, input logic [31:0] a,
                            input logic [31:0] b, input bit rel, input bit pulse10);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          lat;
    int          busy_cnt;
    bit          seen;
    ref_div(sop, a, b, eq, er, ez);
    lat      = 0;
    busy_cnt = 0;
    seen     = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (rel && lat == 1) begin
        i_start     = 1'b0;
        i_dividend  = $urandom;
        i_divisor   = $urandom;
        i_signed_op = ~sop;
      end
      if (pulse10 && lat == 10) begin
        i_start    = 1'b1;
        i_dividend = $urandom;
        i_divisor  = $urandom;
      end
      if (pulse10 && lat == 11) i_start = 1'b0;
      if (o_done) seen = 1;
      else if (o_busy) busy_cnt++;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(lat - 1), 32'd33);
      chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({nm, "_busy_at_done"}, 32'(o_busy), 32'd0);
      chk({nm, "_quotient"}, o_quotient, eq);
      chk({nm, "_remainder"}, o_remainder, er);
      chk({nm, "_dbz"}, 32'(o_div_by_zero), 32'(ez));
      if (rel) begin
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(o_done), 32'd0);
      end
    end
  endtask

  task automatic run(input string nm, input logic sop, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(sop, a, b);
    wait_check(nm, sop, a, b, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        sop;
    int          dones;
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_signed_op = 1'b0;
    i_dividend  = '0;
    i_divisor   = '0;
    #3;
    chk("rst_quotient", o_quotient, 32'd0);
    chk("rst_remainder", o_remainder, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_dbz", 32'(o_div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("udiv_100_7", 1'b0, 32'd100, 32'd7);
    chk("udiv_100_7_q_const", o_quotient, 32'd14);
    chk("udiv_100_7_r_const", o_remainder, 32'd2);
    run("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("sdiv_m100_7_q_const", o_quotient, 32'hFFFF_FFF2);
    chk("sdiv_m100_7_r_const", o_remainder, 32'hFFFF_FFFE);
    run("sdiv_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9);
    run("udiv_by_zero", 1'b0, 32'h0000_1234, 32'd0);
    run("sdiv_by_zero", 1'b1, 32'h0000_1234, 32'd0);
    run("sdiv_neg_by_zero", 1'b1, 32'hFFFF_FF9C, 32'd0);
    run("sdiv_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("sdiv_overflow_q_const", o_quotient, 32'h8000_0000);
    run("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run("udiv_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF);

    // A start pulse while busy must not re-latch.
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd9);
    wait_check("ignore_busy_start", 1'b0, 32'd1000, 32'd9, 1'b1, 1'b1);

    // Start held through done: second operation accepted on the done cycle.
    @(negedge clk);
    issue(1'b1, 32'hFFFF_F000, 32'd3);
    wait_check("held_first", 1'b1, 32'hFFFF_F000, 32'd3, 1'b0, 1'b0);
    issue(1'b0, 32'hDEAD_BEEF, 32'd77);
    wait_check("held_second", 1'b0, 32'hDEAD_BEEF, 32'd77, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sop = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sop = 1'b1; end
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run("rand", sop, a, b);
    end

    // Reset mid-operation, following a nonzero result.
    run("pre_reset", 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    issue(1'b0, 32'd5000, 32'd3);
    @(negedge clk);
    i_start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_quotient", o_quotient, 32'd0);
    chk("midrst_remainder", o_remainder, 32'd0);
    chk("midrst_dbz", 32'(o_div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run("post_reset", 1'b1, 32'hFFFF_FC18, 32'd13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
